// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: NPC select encoding shared with the decoder (ctrl_encode_def values) and request kinds.
// Revision 1.0
`default_nettype none

package pc_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JALR   = 3'd3;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_ERET  = 2'd1,
    REQ_REDIR = 2'd2
  } req_kind_e;

endpackage

`default_nettype wire

// File: rtl/pc_unit_if.sv
// pc_unit_if: pipeline/CSR-side bundle of the PC unit; master = pipeline, slave = pc_unit.
// Revision 1.0
`default_nettype none

interface pc_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic               stall_i;
  logic [2:0]         npc_op_i;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    alu_i;
  logic [XLEN-1:0]    ex_pc_i;
  logic               eret_i;
  logic [XLEN-1:0]    sepc_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic               irq_en_i;
  logic [XLEN-1:0]    pc_o;
  logic               irq_take_o;
  logic [3:0]         irq_cause_o;
  logic [XLEN-1:0]    epc_o;
  logic               in_handler_o;
  logic               misalign_o;

  modport master (
    output stall_i, npc_op_i, imm_i, alu_i, ex_pc_i, eret_i, sepc_i, irq_i, irq_en_i,
    input  pc_o, irq_take_o, irq_cause_o, epc_o, in_handler_o, misalign_o
  );

  modport slave (
    input  stall_i, npc_op_i, imm_i, alu_i, ex_pc_i, eret_i, sepc_i, irq_i, irq_en_i,
    output pc_o, irq_take_o, irq_cause_o, epc_o, in_handler_o, misalign_o
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit_npc_sel.sv
// pc_npc_sel: stateless redirect-target and next-PC priority mux. Option: PC_VECTORED_IRQ_EN.
// Revision 1.0
`default_nettype none

module pc_npc_sel
  import pc_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] INT_VECTOR = 32'h1c09_0000,
  parameter int              NUM_IRQ    = 4
) (
  input  logic [XLEN-1:0]    pc_i,
  input  logic               stall_i,
  input  logic [2:0]         npc_op_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [XLEN-1:0]    alu_i,
  input  logic [XLEN-1:0]    ex_pc_i,
  input  logic               eret_i,
  input  logic [XLEN-1:0]    sepc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               irq_en_i,
  input  logic               in_handler_i,
  input  req_kind_e          hold_kind_i,
  input  logic [XLEN-1:0]    hold_tgt_i,
  output logic [XLEN-1:0]    npc_o,
  output logic               take_o,
  output logic [3:0]         cause_o,
  output logic [XLEN-1:0]    epc_o,
  output logic               misalign_o,
  output logic               eret_apply_o,
  output req_kind_e          live_kind_o,
  output logic [XLEN-1:0]    live_tgt_o
);

  logic            redir_vld;
  logic [XLEN-1:0] redir_tgt;
  req_kind_e       eff_kind;
  logic [XLEN-1:0] eff_tgt;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] vector;

  always_comb begin
    redir_vld = 1'b0;
    redir_tgt = '0;
    case (npc_op_i)
      NPC_BRANCH, NPC_JUMP: begin
        redir_vld = 1'b1;
        redir_tgt = ex_pc_i + imm_i;
      end
      NPC_JALR: begin
        redir_vld = 1'b1;
        redir_tgt = alu_i & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  // A live request always supersedes whatever was parked during a stall.
  assign live_kind_o = eret_i ? REQ_ERET : (redir_vld ? REQ_REDIR : REQ_NONE);
  assign live_tgt_o  = eret_i ? sepc_i : redir_tgt;
  assign eff_kind    = (live_kind_o != REQ_NONE) ? live_kind_o : hold_kind_i;
  assign eff_tgt     = (live_kind_o != REQ_NONE) ? live_tgt_o : hold_tgt_i;
  assign seq_pc      = (eff_kind != REQ_NONE) ? eff_tgt : pc_i + XLEN'(4);

  always_comb begin
    cause_o = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_i[i]) cause_o = 4'(i);
    end
  end

`ifdef PC_VECTORED_IRQ_EN
  assign vector = INT_VECTOR + (XLEN'(cause_o) << 2);
`else
  assign vector = INT_VECTOR;
`endif

  assign take_o       = (|irq_i) & irq_en_i & ~in_handler_i & ~stall_i;
  assign epc_o        = seq_pc;
  assign npc_o        = stall_i ? pc_i : (take_o ? vector : seq_pc);
  assign eret_apply_o = ~stall_i & ~take_o & (eff_kind == REQ_ERET);
  assign misalign_o   = ~stall_i & ~take_o & (eff_kind == REQ_REDIR) & (|eff_tgt[1:0]);

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// pc_unit: PC register, stall hold slot and handler-active flag around pc_npc_sel.
// Revision 1.0. Option: PC_VECTORED_IRQ_EN selects vectored interrupt entry.
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] INT_VECTOR = 32'h1c09_0000,
  parameter int              NUM_IRQ    = 4
) (
  input  logic     clk,
  input  logic     rstn,
  pc_unit_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] hold_tgt_q, hold_tgt_d;
  req_kind_e       hold_kind_q, hold_kind_d;
  logic [3:0]      cause_q, cause_d;
  logic            take_q, in_handler_q, in_handler_d, misalign_q;

  logic            sel_take, sel_misalign, sel_eret_apply;
  logic [3:0]      sel_cause;
  logic [XLEN-1:0] sel_epc, sel_live_tgt;
  req_kind_e       sel_live_kind;

  pc_npc_sel #(
    .XLEN       (XLEN),
    .INT_VECTOR (INT_VECTOR),
    .NUM_IRQ    (NUM_IRQ)
  ) u_npc_sel (
    .pc_i         (pc_q),
    .stall_i      (bus.stall_i),
    .npc_op_i     (bus.npc_op_i),
    .imm_i        (bus.imm_i),
    .alu_i        (bus.alu_i),
    .ex_pc_i      (bus.ex_pc_i),
    .eret_i       (bus.eret_i),
    .sepc_i       (bus.sepc_i),
    .irq_i        (bus.irq_i),
    .irq_en_i     (bus.irq_en_i),
    .in_handler_i (in_handler_q),
    .hold_kind_i  (hold_kind_q),
    .hold_tgt_i   (hold_tgt_q),
    .npc_o        (pc_d),
    .take_o       (sel_take),
    .cause_o      (sel_cause),
    .epc_o        (sel_epc),
    .misalign_o   (sel_misalign),
    .eret_apply_o (sel_eret_apply),
    .live_kind_o  (sel_live_kind),
    .live_tgt_o   (sel_live_tgt)
  );

  // The hold slot only fills while stalled; any unstalled cycle consumes it.
  always_comb begin
    hold_kind_d = hold_kind_q;
    hold_tgt_d  = hold_tgt_q;
    if (bus.stall_i) begin
      if (sel_live_kind != REQ_NONE) begin
        hold_kind_d = sel_live_kind;
        hold_tgt_d  = sel_live_tgt;
      end
    end else begin
      hold_kind_d = REQ_NONE;
    end
    in_handler_d = sel_take ? 1'b1 : (sel_eret_apply ? 1'b0 : in_handler_q);
    cause_d      = sel_take ? sel_cause : cause_q;
    epc_d        = sel_take ? sel_epc : epc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      hold_tgt_q   <= '0;
      hold_kind_q  <= REQ_NONE;
      cause_q      <= 4'd0;
      take_q       <= 1'b0;
      in_handler_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      hold_tgt_q   <= hold_tgt_d;
      hold_kind_q  <= hold_kind_d;
      cause_q      <= cause_d;
      take_q       <= sel_take;
      in_handler_q <= in_handler_d;
      misalign_q   <= sel_misalign;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.irq_take_o   = take_q;
  assign bus.irq_cause_o  = cause_q;
  assign bus.epc_o        = epc_q;
  assign bus.in_handler_o = in_handler_q;
  assign bus.misalign_o   = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus random traffic, checked against a behavioural PC model.
`default_nettype none

module tb_pc_unit;
  import pc_unit_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

  pc_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .INT_VECTOR (32'h1c09_0000),
    .NUM_IRQ    (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

`ifdef PC_VECTORED_IRQ_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  // Model state: hold kind 0 = empty, 1 = eret, 2 = redirect.
  logic [31:0] m_pc, m_epc, m_ht;
  logic [3:0]  m_cause;
  int          m_hk;
  logic        m_inh, m_take, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ht = 32'h0; m_cause = 4'h0;
    m_hk = 0; m_inh = 1'b0; m_take = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step();
    int          lk, ek;
    logic [31:0] lt, et, fall;
    bit          found;
    lk = 0; lt = 32'h0;
    if (bus.eret_i) begin
      lk = 1; lt = bus.sepc_i;
    end else if (bus.npc_op_i == NPC_BRANCH || bus.npc_op_i == NPC_JUMP) begin
      lk = 2; lt = bus.ex_pc_i + bus.imm_i;
    end else if (bus.npc_op_i == NPC_JALR) begin
      lk = 2; lt = {bus.alu_i[31:1], 1'b0};
    end
    ek = (lk != 0) ? lk : m_hk;
    et = (lk != 0) ? lt : m_ht;
    fall = (ek != 0) ? et : m_pc + 32'd4;
    m_mis  = 1'b0;
    m_take = (bus.irq_i != 4'b0) && bus.irq_en_i && !m_inh && !bus.stall_i;
    if (bus.stall_i) begin
      if (lk != 0) begin m_hk = lk; m_ht = lt; end
    end else if (m_take) begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && bus.irq_i[i]) begin m_cause = 4'(i); found = 1'b1; end
      end
      m_epc = fall;
      m_pc  = VECTORED ? 32'h1c09_0000 + 32'(m_cause) * 4 : 32'h1c09_0000;
      m_inh = 1'b1;
      m_hk  = 0;
    end else begin
      m_pc = fall;
      if (ek == 1) m_inh = 1'b0;
      if (ek == 2) m_mis = (et % 4) != 0;
      m_hk = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", bus.pc_o, m_pc);
    chk("irq_take", 32'(bus.irq_take_o), 32'(m_take));
    chk("in_handler", 32'(bus.in_handler_o), 32'(m_inh));
    chk("misalign", 32'(bus.misalign_o), 32'(m_mis));
    if (m_take) begin
      chk("irq_cause", 32'(bus.irq_cause_o), 32'(m_cause));
      chk("epc", bus.epc_o, m_epc);
    end
  endtask

  task automatic set_idle();
    bus.stall_i = 1'b0; bus.npc_op_i = NPC_PLUS4; bus.imm_i = 32'h0; bus.alu_i = 32'h0;
    bus.ex_pc_i = 32'h0; bus.eret_i = 1'b0; bus.sepc_i = 32'h0; bus.irq_i = 4'b0; bus.irq_en_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, bus.pc_o, 32'h0);
    chk({tag, "_take"}, 32'(bus.irq_take_o), 32'h0);
    chk({tag, "_cause"}, 32'(bus.irq_cause_o), 32'h0);
    chk({tag, "_epc"}, bus.epc_o, 32'h0);
    chk({tag, "_inh"}, 32'(bus.in_handler_o), 32'h0);
    chk({tag, "_mis"}, 32'(bus.misalign_o), 32'h0);
  endtask

  initial begin
    logic [31:0] exp_vec0, exp_vec1, exp_vec3;
    exp_vec0 = 32'h1c09_0000;
    exp_vec1 = VECTORED ? 32'h1c09_0004 : 32'h1c09_0000;
    exp_vec3 = VECTORED ? 32'h1c09_000c : 32'h1c09_0000;

    set_idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_state("rst");
    @(negedge clk) rstn = 1'b1;
    tick(); chk("boot_4", bus.pc_o, 32'h4);
    tick(); chk("boot_8", bus.pc_o, 32'h8);

    // Branch and misaligned branch
    bus.npc_op_i = NPC_JUMP; bus.ex_pc_i = 32'h0; bus.imm_i = 32'h40;
    tick(); chk("jump_40", bus.pc_o, 32'h40);
    bus.npc_op_i = NPC_BRANCH; bus.ex_pc_i = 32'h38; bus.imm_i = 32'h20;
    tick(); chk("br_58", bus.pc_o, 32'h58); chk("br_58_mis", 32'(bus.misalign_o), 32'h0);
    bus.imm_i = 32'h22;
    tick(); chk("br_5a", bus.pc_o, 32'h5a); chk("br_5a_mis", 32'(bus.misalign_o), 32'h1);

    // JALR parked in the hold slot across a stall
    set_idle(); bus.stall_i = 1'b1; bus.npc_op_i = NPC_JALR; bus.alu_i = 32'h101;
    tick(); chk("stall_pc0", bus.pc_o, 32'h5a);
    bus.npc_op_i = NPC_PLUS4;
    tick(); tick(); chk("stall_pc2", bus.pc_o, 32'h5a);
    bus.stall_i = 1'b0;
    tick(); chk("hold_jalr", bus.pc_o, 32'h100); chk("hold_jalr_mis", 32'(bus.misalign_o), 32'h0);

    // Interrupt take, masked while in handler
    bus.npc_op_i = NPC_JUMP; bus.imm_i = 32'h80;
    tick(); chk("jump_80", bus.pc_o, 32'h80);
    set_idle(); bus.irq_i = 4'b0110; bus.irq_en_i = 1'b1;
    tick();
    chk("irq_take", 32'(bus.irq_take_o), 32'h1); chk("irq_cause", 32'(bus.irq_cause_o), 32'h1);
    chk("irq_epc", bus.epc_o, 32'h84); chk("irq_vec", bus.pc_o, exp_vec1);
    repeat (3) tick();
    chk("irq_masked", 32'(bus.irq_take_o), 32'h0); chk("irq_masked_pc", bus.pc_o, exp_vec1 + 32'd12);
    bus.irq_i = 4'b0; bus.eret_i = 1'b1; bus.sepc_i = 32'h84;
    tick(); chk("eret_pc", bus.pc_o, 32'h84); chk("eret_inh", 32'(bus.in_handler_o), 32'h0);

    // Interrupt colliding with eret
    bus.eret_i = 1'b1; bus.sepc_i = 32'h200; bus.irq_i = 4'b0001;
    tick();
    chk("col_take", 32'(bus.irq_take_o), 32'h1); chk("col_epc", bus.epc_o, 32'h200);
    chk("col_inh", 32'(bus.in_handler_o), 32'h1); chk("col_pc", bus.pc_o, exp_vec0);
    bus.irq_i = 4'b0;
    tick(); chk("col_eret_pc", bus.pc_o, 32'h200); chk("col_eret_inh", 32'(bus.in_handler_o), 32'h0);

    // Interrupt deferred by stall
    set_idle(); bus.stall_i = 1'b1; bus.irq_i = 4'b1000; bus.irq_en_i = 1'b1;
    repeat (3) begin
      tick(); chk("stall_irq_none", 32'(bus.irq_take_o), 32'h0);
    end
    bus.stall_i = 1'b0;
    tick(); chk("stall_irq_take", 32'(bus.irq_take_o), 32'h1); chk("stall_irq_pc", bus.pc_o, exp_vec3);
    chk("stall_irq_epc", bus.epc_o, 32'h204);
    set_idle(); bus.eret_i = 1'b1; bus.sepc_i = 32'h300;
    tick();

    // Random traffic
    repeat (500) begin
      bus.npc_op_i = ($urandom_range(0, 2) != 0) ? NPC_PLUS4 : 3'($urandom_range(0, 7));
      bus.imm_i    = $urandom;
      bus.alu_i    = $urandom;
      bus.ex_pc_i  = $urandom;
      bus.stall_i  = ($urandom_range(0, 3) == 0);
      bus.eret_i   = ($urandom_range(0, 7) == 0);
      bus.sepc_i   = $urandom;
      bus.irq_i    = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      bus.irq_en_i = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset mid-run
    set_idle();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_state("arst");
    @(negedge clk) rstn = 1'b1;
    #1 chk("arst_rel_0", bus.pc_o, 32'h0);
    tick(); chk("arst_rel_4", bus.pc_o, 32'h4);
    tick(); chk("arst_rel_8", bus.pc_o, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
